// File: rtl/lector_instrucciones_if.sv
// Instruction-fetch handshake between program_counter, lector_instrucciones and the
// instruction memory. The slave modport is the lector; master covers the PC and memory side.
interface lector_instrucciones_if #(
    parameter int unsigned ANCHO_DIR  = 14,
    parameter int unsigned ANCHO_DATO = 32
);
    logic                  reiniciar;
    logic                  leer_siguiente_inst;
    logic [ANCHO_DIR-1:0]  direccion_siguiente_inst;
    logic                  lectura_completada;
    logic [ANCHO_DATO-1:0] instruccion_actual;
    logic                  ocupado;
    logic                  fin_programa;
    logic                  mem_leer;
    logic [ANCHO_DIR-1:0]  mem_direccion;
    logic [ANCHO_DATO-1:0] mem_dato;

    modport slave (
        input  reiniciar,
        input  leer_siguiente_inst,
        input  direccion_siguiente_inst,
        input  mem_dato,
        output lectura_completada,
        output instruccion_actual,
        output ocupado,
        output fin_programa,
        output mem_leer,
        output mem_direccion
    );

    modport master (
        output reiniciar,
        output leer_siguiente_inst,
        output direccion_siguiente_inst,
        output mem_dato,
        input  lectura_completada,
        input  instruccion_actual,
        input  ocupado,
        input  fin_programa,
        input  mem_leer,
        input  mem_direccion
    );
endinterface

// File: rtl/lector_instrucciones.sv
// Instruction fetch responder: takes one request from program_counter, reads a fixed-latency
// synchronous memory and delivers the word with a one-cycle pulse. One pending request is held.
module lector_instrucciones #(
    parameter int unsigned           ANCHO_DIR    = 14,
    parameter int unsigned           ANCHO_DATO   = 32,
    parameter int unsigned           LATENCIA_MEM = 2,
    parameter logic [ANCHO_DATO-1:0] INST_FIN     = 32'hFFFF_FFFF
) (
    input logic                    clk,
    input logic                    reset,
    lector_instrucciones_if.slave  bus
);

    localparam int unsigned            ANCHO_CNT = $clog2(LATENCIA_MEM) + 1;
    localparam logic [ANCHO_CNT-1:0]   CNT_INI   = ANCHO_CNT'(LATENCIA_MEM - 1);

    typedef enum logic [1:0] {
        StReposo,
        StLeer,
        StEsperar,
        StEntregar
    } estado_t;

    estado_t               r_estado;
    estado_t               w_estado_sig;
    logic [ANCHO_CNT-1:0]  r_cnt;
    logic                  r_pend;
    logic [ANCHO_DIR-1:0]  r_pend_dir;
    logic [ANCHO_DIR-1:0]  r_dir;
    logic [ANCHO_DATO-1:0] r_inst;
    logic                  r_fin;
    logic                  w_captura;

    // Data of the in-flight read is valid on the edge where the counter has run out.
    assign w_captura = (r_estado == StEsperar) && (r_cnt == '0) && !bus.reiniciar;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= StReposo;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        if (bus.reiniciar) begin
            w_estado_sig = StReposo;
        end else begin
            unique case (r_estado)
                StReposo:   if (bus.leer_siguiente_inst) w_estado_sig = StLeer;
                StLeer:     w_estado_sig = StEsperar;
                StEsperar:  if (r_cnt == '0) w_estado_sig = StEntregar;
                StEntregar: begin
                    if (r_pend || bus.leer_siguiente_inst) begin
                        w_estado_sig = StLeer;
                    end else begin
                        w_estado_sig = StReposo;
                    end
                end
                default:    w_estado_sig = StReposo;
            endcase
        end
    end

    always_comb begin
        bus.mem_leer           = 1'b0;
        bus.lectura_completada = 1'b0;
        bus.ocupado            = r_pend;
        if (r_estado == StLeer)     bus.mem_leer = 1'b1;
        if (r_estado == StEntregar) bus.lectura_completada = 1'b1;
        if (r_estado != StReposo)   bus.ocupado = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_dir <= '0;
            r_dir      <= '0;
            r_inst     <= '0;
            r_fin      <= 1'b0;
        end else if (bus.reiniciar) begin
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_dir <= '0;
            r_fin      <= 1'b0;
        end else begin
            if (r_estado == StLeer) begin
                r_cnt <= CNT_INI;
            end else if ((r_estado == StEsperar) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_captura) begin
                r_inst <= bus.mem_dato;
                if (bus.mem_dato == INST_FIN) r_fin <= 1'b1;
            end

            // A request in the delivery cycle wins over the stored one (last wins).
            unique case (r_estado)
                StReposo: begin
                    if (bus.leer_siguiente_inst) r_dir <= bus.direccion_siguiente_inst;
                end
                StEntregar: begin
                    if (bus.leer_siguiente_inst) begin
                        r_dir <= bus.direccion_siguiente_inst;
                    end else if (r_pend) begin
                        r_dir <= r_pend_dir;
                    end
                    r_pend <= 1'b0;
                end
                default: begin
                    if (bus.leer_siguiente_inst) begin
                        r_pend     <= 1'b1;
                        r_pend_dir <= bus.direccion_siguiente_inst;
                    end
                end
            endcase
        end
    end

    assign bus.mem_direccion      = r_dir;
    assign bus.instruccion_actual = r_inst;
    assign bus.fin_programa       = r_fin;

endmodule
